// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Purpose : UART frame constants shared by the receive path.
// Contents: DATA_BITS - payload bits per frame (LSB first on the line)
//           STOP_BITS - stop bits per frame (the receiver checks exactly one)
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : Single-clock show-ahead FIFO. dout always presents the head entry;
//           it is meaningful only while empty=0.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset (pointers, count, storage)
//           push  - write din at the tail; dropped when full unless pop also
//                   succeeds in the same cycle
//           pop   - consume the head entry; ignored when empty
//           din   - write data
//           dout  - head data (show-ahead)
//           empty - no entries held
//           full  - DEPTH entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q,  count_d;
    logic             do_push,  do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same edge, so a push into a full FIFO
    // is accepted whenever a pop also succeeds.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : 8N1 UART receiver feeding a show-ahead byte FIFO.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-high reset
//           rx        - serial line, asynchronous to clk, idle high
//           rd        - pop request; consumes the head byte when rx_full=1
//           rx_data   - FIFO head byte, valid while rx_full=1
//           rx_full   - FIFO non-empty
//           frame_err - one-cycle pulse on a bad (low) stop bit
//           overrun   - one-cycle pulse when a byte is dropped on a full FIFO
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLOCK_HZ  = 27_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned TIM_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned PERIOD = CLOCK_HZ / BAUD;
    localparam logic [TIM_WIDTH-1:0] PER_M1 = TIM_WIDTH'(PERIOD - 1);
    localparam logic [TIM_WIDTH-1:0] HALF   = TIM_WIDTH'(PERIOD / 2);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    if ((PERIOD < 2) || (((PERIOD - 1) >> TIM_WIDTH) != 0)) begin : g_bad_period
        $fatal(1, "uart_rx_fifo: CLOCK_HZ/BAUD - 1 must fit in TIM_WIDTH bits");
    end

    if (STOP_BITS != 1) begin : g_bad_stop
        $fatal(1, "uart_rx_fifo: only one stop bit is supported");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    rx_state_e state_q, state_d;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TIM_WIDTH-1:0] cnt_q,   cnt_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic fifo_full;
    logic fall;

    // rx_prev_q delays the synchronized line by one more cycle for edge
    // detection; all three flops reset high so reset never looks like a start.
    assign fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            // Re-check the line at the start-bit midpoint; a high line here
            // was a glitch and the frame is abandoned.
            StStart: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StData: begin
                if (cnt_q == PER_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStop: begin
                if (cnt_q == PER_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A held-low line (break) must not start new frames; wait for idle.
            StWaitHigh: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign pop       = rd & ~fifo_empty;
    assign overrun_d = push & fifo_full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_full   = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
